droute_switch_sched: RTL and testbench

Command sequencer for the two `inter_switch` instances inside `data_route`. It buffers switch-configuration commands in a small FIFO and issues each 18-bit ctrl word to the selected switch, `s_droute_switch_0` or `s_droute_switch_1`. It holds that word until the switch reports completion on `count_switch_N_tvalid`, then idles the switch before the next command. A barrier flag lets software order commands across both switches.

---
 rtl/droute_switch_sched.sv | 115 +++++++++++
 tb/tb_droute_switch_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/droute_switch_sched.sv
// droute_switch_sched: in-order command FIFO feeding two inter_switch ctrl words (watchdog via DROUTE_SCHED_WDOG_EN)
module droute_switch_sched #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [19:0]            s_cmd_tdata,
  input  logic                   s_cmd_tvalid,
  output logic                   s_cmd_tready,
  output logic [17:0]            switch_0_ctrl,
  output logic [17:0]            switch_1_ctrl,
  input  logic                   switch_0_done,
  input  logic                   switch_1_done,
  output logic [1:0]             busy,
  output logic                   cmd_done,
  output logic [15:0]            done_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [1:0]             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;
  logic [19:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  state_e            st_q [2];
  state_e            st_d [2];
  logic [1:0][17:0]  ctrl_q, ctrl_d;
  logic [1:0]        busy_q, busy_d, dn, to, idle;
  logic              cmd_done_q, cmd_done_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [19:0]       head;
  logic              head_v, push, issue, sel;
  assign head         = mem_q[rd_q];
  assign head_v       = lvl_q != '0;
  assign sel          = head[18];
  assign s_cmd_tready = lvl_q < LW'(DEPTH);
  assign push         = s_cmd_tvalid & s_cmd_tready;
  assign idle         = {st_q[1] == IDLE, st_q[0] == IDLE};
  assign issue        = head_v & (head[19] ? &idle : idle[sel]);
  assign dn           = {switch_1_done & (st_q[1] == BUSY), switch_0_done & (st_q[0] == BUSY)};
  assign fifo_level    = lvl_q;
  assign switch_0_ctrl = ctrl_q[0];
  assign switch_1_ctrl = ctrl_q[1];
  assign busy          = busy_q;
  assign cmd_done      = cmd_done_q;
  assign done_cnt      = cnt_q;
  // FIFO storage is not reset; only the pointers and level define its contents
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= s_cmd_tdata;
  // next-state: FIFO pointers, per-switch FSMs, completion accounting
  always_comb begin
    wr_d       = push ? wr_q + AW'(1) : wr_q;
    rd_d       = issue ? rd_q + AW'(1) : rd_q;
    lvl_d      = lvl_q + LW'(push) - LW'(issue);
    busy_d     = '0;
    cmd_done_d = |dn;
    cnt_d      = cnt_q + 16'(dn[0]) + 16'(dn[1]);
    for (int n = 0; n < 2; n++) begin
      st_d[n]   = st_q[n];
      ctrl_d[n] = ctrl_q[n];
      if (st_q[n] == IDLE && issue && sel == 1'(n)) begin
        st_d[n]   = BUSY;
        ctrl_d[n] = head[17:0];
      end else if (st_q[n] == BUSY && (dn[n] || to[n])) begin
        st_d[n]   = DRAIN;
        ctrl_d[n] = '0;
      end else if (st_q[n] == DRAIN) begin
        st_d[n] = IDLE;
      end
      busy_d[n] = st_d[n] == BUSY;
    end
  end
  // state registers; reset flushes the FIFO and idles both switches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      lvl_q      <= '0;
      ctrl_q     <= '0;
      busy_q     <= '0;
      cmd_done_q <= 1'b0;
      cnt_q      <= '0;
      for (int n = 0; n < 2; n++) st_q[n] <= IDLE;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      lvl_q      <= lvl_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      cmd_done_q <= cmd_done_d;
      cnt_q      <= cnt_d;
      for (int n = 0; n < 2; n++) st_q[n] <= st_d[n];
    end
`ifdef DROUTE_SCHED_WDOG_EN
  logic [1:0][31:0] wd_q;
  logic [1:0]       err_q;
  assign to[0] = (st_q[0] == BUSY) && (wd_q[0] == 32'(TIMEOUT - 1)) && !dn[0];
  assign to[1] = (st_q[1] == BUSY) && (wd_q[1] == 32'(TIMEOUT - 1)) && !dn[1];
  assign err   = err_q;
  // busy-cycle watchdogs; a real completion on the limit cycle wins over the timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) wd_q[n] <= (st_q[n] == BUSY) ? wd_q[n] + 32'd1 : '0;
      err_q <= err_q | to;
    end
`else
  assign to  = 2'b00;
  assign err = 2'b00;
`endif
endmodule

// File: tb/tb_droute_switch_sched.sv
// tb_droute_switch_sched: directed and randomized checks against a queue-based scheduler model
module tb_droute_switch_sched;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] s_cmd_tdata = '0;
  logic        s_cmd_tvalid = 1'b0;
  logic        s_cmd_tready;
  logic [17:0] switch_0_ctrl, switch_1_ctrl;
  logic        switch_0_done = 1'b0;
  logic        switch_1_done = 1'b0;
  logic [1:0]  busy, err;
  logic        cmd_done;
  logic [15:0] done_cnt;
  logic [3:0]  fifo_level;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  droute_switch_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .switch_0_ctrl(switch_0_ctrl), .switch_1_ctrl(switch_1_ctrl),
    .switch_0_done(switch_0_done), .switch_1_done(switch_1_done),
    .busy(busy), .cmd_done(cmd_done), .done_cnt(done_cnt),
    .fifo_level(fifo_level), .err(err)
  );
  // reference model: pending commands, per-switch word/activity, cooldown before reuse
  logic [19:0] mq [$];
  logic [17:0] m_word [2];
  bit          m_act [2];
  int          m_cool [2];
  int          m_age [2];
  bit          m_done;
  logic [15:0] m_cnt;
  logic [1:0]  m_err;
  task automatic m_reset();
    mq.delete();
    for (int n = 0; n < 2; n++) begin
      m_word[n] = '0; m_act[n] = 0; m_cool[n] = 0; m_age[n] = 0;
    end
    m_done = 0; m_cnt = '0; m_err = '0;
  endtask
  task automatic tick(input bit pv, input logic [19:0] pd, input bit d0, input bit d1);
    bit dn [2];
    bit av [2];
    bit acc;
    logic [19:0] h;
    s_cmd_tvalid = pv; s_cmd_tdata = pd; switch_0_done = d0; switch_1_done = d1;
    acc   = pv && mq.size() < DEPTH;
    dn[0] = d0 && m_act[0];
    dn[1] = d1 && m_act[1];
    for (int n = 0; n < 2; n++) begin
      av[n] = !m_act[n] && m_cool[n] == 0;
      if (m_cool[n] > 0) m_cool[n]--;
    end
    m_done = dn[0] || dn[1];
    m_cnt  = m_cnt + 16'(int'(dn[0]) + int'(dn[1]));
    for (int n = 0; n < 2; n++)
      if (m_act[n]) begin
        m_age[n]++;
        if (dn[n]) begin
          m_act[n] = 0; m_word[n] = '0; m_cool[n] = 1;
        end
`ifdef DROUTE_SCHED_WDOG_EN
        else if (m_age[n] == TIMEOUT) begin
          m_act[n] = 0; m_word[n] = '0; m_cool[n] = 1; m_err[n] = 1'b1;
        end
`endif
      end
    if (mq.size() > 0) begin
      h = mq[0];
      if (h[19] ? (av[0] && av[1]) : av[h[18]]) begin
        void'(mq.pop_front());
        m_act[h[18]] = 1; m_word[h[18]] = h[17:0]; m_age[h[18]] = 0;
      end
    end
    if (acc) mq.push_back(pd);
    @(posedge clk);
    #1;
    s_cmd_tvalid = 0; switch_0_done = 0; switch_1_done = 0;
  endtask
  task automatic test_reset();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({switch_1_ctrl, switch_0_ctrl} !== 36'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {switch_1_ctrl, switch_0_ctrl}); end
    checks++; if (busy !== 2'b00 || cmd_done !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 00/0", busy, cmd_done); end
    checks++; if (done_cnt !== 16'd0 || err !== 2'b00) begin errors++; $display("FAIL reset_cnt got %h/%b want 0/00", done_cnt, err); end
    checks++; if (fifo_level !== 4'd0 || s_cmd_tready !== 1'b1) begin errors++; $display("FAIL reset_fifo got %0d/%b want 0/1", fifo_level, s_cmd_tready); end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_basic();
    tick(1, 20'h00009, 0, 0);
    checks++; if (fifo_level !== 4'd1 || switch_0_ctrl !== 18'd0) begin errors++; $display("FAIL basic_accept got lvl %0d ctrl %h want 1/0", fifo_level, switch_0_ctrl); end
    tick(0, '0, 0, 0);
    checks++; if (switch_0_ctrl !== 18'h00009 || busy !== 2'b01) begin errors++; $display("FAIL basic_issue got %h/%b want 00009/01", switch_0_ctrl, busy); end
    for (int i = 0; i < 9; i++) begin
      tick(0, '0, 0, 0);
      checks++; if (switch_0_ctrl !== 18'h00009 || cmd_done !== 1'b0) begin errors++; $display("FAIL basic_hold got %h/%b want 00009/0", switch_0_ctrl, cmd_done); end
    end
    tick(0, '0, 1, 0);
    checks++; if (switch_0_ctrl !== 18'd0 || busy !== 2'b00) begin errors++; $display("FAIL basic_clear got %h/%b want 0/00", switch_0_ctrl, busy); end
    checks++; if (cmd_done !== 1'b1 || done_cnt !== 16'd1) begin errors++; $display("FAIL basic_done got %b/%0d want 1/1", cmd_done, done_cnt); end
    tick(0, '0, 0, 0);
    checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", cmd_done); end
  endtask
  task automatic test_parallel();
    tick(1, 20'h00024, 0, 0);
    tick(1, 20'h40012, 0, 0);
    checks++; if (switch_0_ctrl !== 18'h00024 || switch_1_ctrl !== 18'd0) begin errors++; $display("FAIL par_first got %h/%h want 00024/0", switch_0_ctrl, switch_1_ctrl); end
    tick(0, '0, 0, 0);
    checks++; if (switch_1_ctrl !== 18'h00012 || busy !== 2'b11) begin errors++; $display("FAIL par_second got %h/%b want 00012/11", switch_1_ctrl, busy); end
    tick(0, '0, 1, 1);
    checks++; if (cmd_done !== 1'b1 || done_cnt !== 16'd3 || busy !== 2'b00) begin errors++; $display("FAIL par_done got %b/%0d/%b want 1/3/00", cmd_done, done_cnt, busy); end
    tick(0, '0, 0, 0);
    checks++; if (cmd_done !== 1'b0 || done_cnt !== 16'd3) begin errors++; $display("FAIL par_single got %b/%0d want 0/3", cmd_done, done_cnt); end
  endtask
  task automatic test_barrier();
    tick(1, 20'h00111, 0, 0);
    tick(1, 20'hC0222, 0, 0);
    for (int i = 0; i < 17; i++) begin
      tick(0, '0, 0, 0);
      checks++; if (switch_1_ctrl !== 18'd0 || fifo_level !== 4'd1) begin errors++; $display("FAIL bar_block got %h/%0d want 0/1", switch_1_ctrl, fifo_level); end
    end
    tick(0, '0, 1, 0);
    checks++; if (switch_1_ctrl !== 18'd0 || switch_0_ctrl !== 18'd0) begin errors++; $display("FAIL bar_done got %h/%h want 0/0", switch_1_ctrl, switch_0_ctrl); end
    tick(0, '0, 0, 0);
    checks++; if (switch_1_ctrl !== 18'd0) begin errors++; $display("FAIL bar_drain got %h want 0", switch_1_ctrl); end
    tick(0, '0, 0, 0);
    checks++; if (switch_1_ctrl !== 18'h00222 || fifo_level !== 4'd0) begin errors++; $display("FAIL bar_issue got %h/%0d want 00222/0", switch_1_ctrl, fifo_level); end
    tick(0, '0, 0, 1);
    tick(0, '0, 0, 0);
    checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL bar_cnt got %0d want 5", done_cnt); end
  endtask
  task automatic test_fifo_full();
    logic [17:0] got [$];
    tick(1, 20'h00055, 0, 0);
    tick(1, 20'h40066, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 20'h00100 + 20'(i), 0, 0);
    checks++; if (fifo_level !== 4'd8 || s_cmd_tready !== 1'b0) begin errors++; $display("FAIL full_level got %0d/%b want 8/0", fifo_level, s_cmd_tready); end
    checks++; if (switch_0_ctrl !== 18'h00055 || switch_1_ctrl !== 18'h00066) begin errors++; $display("FAIL full_hold got %h/%h want 00055/00066", switch_0_ctrl, switch_1_ctrl); end
    for (int i = 0; i < 40; i++) begin
      tick(0, '0, m_act[0], 0);
      if (switch_0_ctrl !== 18'd0) got.push_back(switch_0_ctrl);
    end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL full_count got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== 18'h00100 + 18'(i)) begin errors++; $display("FAIL full_order[%0d] got %h want %h", i, got[i], 18'h00100 + 18'(i)); end
    end
    tick(0, '0, 0, 1);
    tick(0, '0, 0, 0);
    checks++; if (done_cnt !== m_cnt || busy !== 2'b00) begin errors++; $display("FAIL full_cnt got %0d/%b want %0d/00", done_cnt, busy, m_cnt); end
  endtask
  task automatic test_spurious_reset();
    logic [15:0] saved;
    saved = m_cnt;
    tick(0, '0, 1, 1);
    checks++; if (cmd_done !== 1'b0 || done_cnt !== saved) begin errors++; $display("FAIL spur got %b/%0d want 0/%0d", cmd_done, done_cnt, saved); end
    tick(1, 20'h00301, 0, 0);
    tick(1, 20'h00302, 0, 0);
    tick(1, 20'h00303, 0, 0);
    tick(1, 20'h00304, 0, 0);
    checks++; if (fifo_level !== 4'd3 || switch_0_ctrl !== 18'h00301) begin errors++; $display("FAIL rst_pre got %0d/%h want 3/00301", fifo_level, switch_0_ctrl); end
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (switch_0_ctrl !== 18'd0 || fifo_level !== 4'd0 || s_cmd_tready !== 1'b1) begin errors++; $display("FAIL rst_async got %h/%0d/%b want 0/0/1", switch_0_ctrl, fifo_level, s_cmd_tready); end
    checks++; if (busy !== 2'b00 || done_cnt !== 16'd0) begin errors++; $display("FAIL rst_state got %b/%0d want 00/0", busy, done_cnt); end
    @(negedge clk) rst_n = 1'b1;
    tick(0, '0, 0, 0);
    checks++; if (switch_0_ctrl !== 18'd0 || fifo_level !== 4'd0) begin errors++; $display("FAIL rst_flush got %h/%0d want 0/0", switch_0_ctrl, fifo_level); end
  endtask
`ifdef DROUTE_SCHED_WDOG_EN
  task automatic test_watchdog();
    logic [15:0] saved;
    saved = m_cnt;
    tick(1, 20'h00AAA, 0, 0);
    tick(0, '0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      tick(0, '0, 0, 0);
      checks++; if (switch_0_ctrl !== 18'h00AAA || err !== 2'b00) begin errors++; $display("FAIL wd_hold got %h/%b want 00AAA/00", switch_0_ctrl, err); end
    end
    tick(0, '0, 0, 0);
    checks++; if (switch_0_ctrl !== 18'd0 || err !== 2'b01) begin errors++; $display("FAIL wd_fire got %h/%b want 0/01", switch_0_ctrl, err); end
    checks++; if (cmd_done !== 1'b0 || done_cnt !== saved) begin errors++; $display("FAIL wd_nocnt got %b/%0d want 0/%0d", cmd_done, done_cnt, saved); end
    tick(1, 20'h00BBB, 0, 0);
    tick(0, '0, 0, 0);
    checks++; if (switch_0_ctrl !== 18'h00BBB || err !== 2'b01) begin errors++; $display("FAIL wd_next got %h/%b want 00BBB/01", switch_0_ctrl, err); end
    tick(0, '0, 1, 0);
    tick(0, '0, 0, 0);
  endtask
`endif
  task automatic test_random();
    logic [19:0] d;
    for (int i = 0; i < 800; i++) begin
      d = 20'($urandom);
      d[19] = ($urandom % 8) == 0;
      tick(($urandom % 3) != 0, d, ($urandom % 5) == 0, ($urandom % 5) == 0);
      checks++; if ({switch_1_ctrl, switch_0_ctrl} !== {m_word[1], m_word[0]}) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %h want %h", i, {switch_1_ctrl, switch_0_ctrl}, {m_word[1], m_word[0]}); end
      checks++; if ({busy, cmd_done, err} !== {m_act[1], m_act[0], m_done, m_err}) begin errors++; $display("FAIL rnd_stat cyc %0d got %b want %b", i, {busy, cmd_done, err}, {m_act[1], m_act[0], m_done, m_err}); end
      checks++; if ({done_cnt, fifo_level, s_cmd_tready} !== {m_cnt, 4'(mq.size()), mq.size() < DEPTH}) begin errors++; $display("FAIL rnd_fifo cyc %0d got %h/%0d/%b want %h/%0d/%b", i, done_cnt, fifo_level, s_cmd_tready, m_cnt, mq.size(), mq.size() < DEPTH); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_parallel();
    test_barrier();
    test_fifo_full();
    test_spurious_reset();
`ifdef DROUTE_SCHED_WDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
